// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, op encodings, interrupt codes and mstatus bit positions
package csr_pkg;
   typedef enum logic [1:0] {OP_NONE = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} csr_op_e;
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
   localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;
   localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
   localparam logic [11:0] CSR_MARCHID       = 12'hF12;
   localparam logic [11:0] CSR_MIMPID        = 12'hF13;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;
   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MIE           = 12'h304;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;
   localparam logic [11:0] CSR_MIP           = 12'h344;
   localparam logic [4:0]  IRQ_MSI           = 5'd3;
   localparam logic [4:0]  IRQ_MTI           = 5'd7;
   localparam logic [4:0]  IRQ_MEI           = 5'd11;
   localparam int          MSTATUS_MIE       = 3;
   localparam int          MSTATUS_MPIE      = 7;
   localparam logic [31:0] MSTATUS_MPP       = 32'h0000_1800;
   localparam logic [31:0] MIE_MASK          = 32'h0000_0888;
   localparam logic [31:0] MISA_VAL          = 32'h4000_0100;
endpackage

// File: rtl/csr_counter.sv
// csr_counter: wide event counter with independently writable 32-bit low/high halves
module csr_counter #(
   parameter int CNT_WIDTH = 64
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 inc_i,
   input  logic                 inhibit_i,
   input  logic                 we_lo_i,
   input  logic                 we_hi_i,
   input  logic [31:0]          wdata_i,
   output logic [CNT_WIDTH-1:0] value_o
);
   logic [CNT_WIDTH-1:0] value_q;
   always_ff @(posedge clk_i) begin
      if (rst_i) value_q <= '0;
      else if (we_lo_i) value_q <= {value_q[CNT_WIDTH-1:32], wdata_i};
      else if (we_hi_i) value_q <= {wdata_i[CNT_WIDTH-33:0], value_q[31:0]};
      else if (inc_i && !inhibit_i) value_q <= value_q + CNT_WIDTH'(1);
   end
   assign value_o = value_q;
endmodule

// File: rtl/csr_file_trap.sv
// csr_file_trap: machine-mode CSR file with counters, trap/mret sequencing and interrupts
module csr_file_trap
   import csr_pkg::*;
#(
   parameter logic [31:0] VEND_ID     = 32'h0,
   parameter logic [31:0] ARCH_ID     = 32'h0,
   parameter logic [31:0] IMPL_ID     = 32'h0,
   parameter logic [31:0] HART_ID     = 32'h0,
   parameter int          NUM_HPM     = 4,
   parameter int          CNT_WIDTH   = 64,
   parameter logic [31:0] MTVEC_RESET = 32'h0
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [11:0]        addr_i,
   input  logic [31:0]        data_i,
   input  logic [1:0]         op_i,
   input  logic               we_i,
   output logic [31:0]        data_o,
   output logic               illegal_o,
   input  logic               instr_retired_i,
   input  logic [NUM_HPM-1:0] hpm_event_i,
   input  logic               irq_ext_i,
   input  logic               irq_timer_i,
   input  logic               irq_soft_i,
   input  logic               trap_i,
   input  logic [4:0]         trap_cause_i,
   input  logic               trap_is_intr_i,
   input  logic [31:0]        trap_epc_i,
   input  logic [31:0]        trap_tval_i,
   input  logic               mret_i,
   output logic [31:0]        trap_vec_o,
   output logic [31:0]        mepc_o,
   output logic               intr_pending_o,
   output logic [4:0]         intr_cause_o
);
   localparam int          HN       = (NUM_HPM > 0) ? NUM_HPM : 1;
   localparam logic [31:0] MCI_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);
   logic                 mstatus_mie_q, mstatus_mpie_q;
   logic [31:0]          mtvec_q, mie_q, mscratch_q, mepc_q, mcause_q, mtval_q, mcinh_q;
   logic [2:0]           irq_q;
   logic [CNT_WIDTH-1:0] cy_val, ir_val;
   logic [CNT_WIDTH-1:0] hpm_val [HN];
   logic [31:0]          rdata, wval, mstatus, mip, pend, tbase;
   logic                 impl, wr;
   assign mstatus = MSTATUS_MPP | ({31'b0, mstatus_mpie_q} << MSTATUS_MPIE) | ({31'b0, mstatus_mie_q} << MSTATUS_MIE);
   assign mip     = {20'b0, irq_q[2], 3'b0, irq_q[1], 3'b0, irq_q[0], 3'b0};
   always_comb begin
      rdata = '0;
      impl  = 1'b1;
      case (addr_i)
         CSR_CYCLE, CSR_MCYCLE:       rdata = cy_val[31:0];
         CSR_CYCLEH, CSR_MCYCLEH:     rdata = 32'(cy_val >> 32);
         CSR_INSTRET, CSR_MINSTRET:   rdata = ir_val[31:0];
         CSR_INSTRETH, CSR_MINSTRETH: rdata = 32'(ir_val >> 32);
         CSR_MVENDORID:               rdata = VEND_ID;
         CSR_MARCHID:                 rdata = ARCH_ID;
         CSR_MIMPID:                  rdata = IMPL_ID;
         CSR_MHARTID:                 rdata = HART_ID;
         CSR_MISA:                    rdata = MISA_VAL;
         CSR_MSTATUS:                 rdata = mstatus;
         CSR_MSTATUSH:                rdata = '0;
         CSR_MTVEC:                   rdata = mtvec_q;
         CSR_MIE:                     rdata = mie_q;
         CSR_MIP:                     rdata = mip;
         CSR_MSCRATCH:                rdata = mscratch_q;
         CSR_MEPC:                    rdata = mepc_q;
         CSR_MCAUSE:                  rdata = mcause_q;
         CSR_MTVAL:                   rdata = mtval_q;
         CSR_MCOUNTINHIBIT:           rdata = mcinh_q;
         default: begin
            impl = 1'b0;
            for (int i = 0; i < NUM_HPM; i++) begin
               if (addr_i == CSR_MHPMCOUNTER3 + 12'(i)) begin rdata = hpm_val[i][31:0]; impl = 1'b1; end
               if (addr_i == CSR_MHPMCOUNTER3H + 12'(i)) begin rdata = 32'(hpm_val[i] >> 32); impl = 1'b1; end
               if (addr_i == CSR_MHPMEVENT3 + 12'(i)) impl = 1'b1;
            end
         end
      endcase
   end
   assign data_o    = rdata;
   assign illegal_o = !impl || (we_i && op_i != OP_NONE && addr_i[11:10] == 2'b11);
   assign wval      = (op_i == OP_RW) ? data_i : (op_i == OP_RS) ? (rdata | data_i) : (rdata & ~data_i);
   // trap and mret outrank the CSR write, which is then dropped
   assign wr        = we_i && op_i != OP_NONE && !illegal_o && !trap_i && !mret_i;
   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cycle (
      .clk_i, .rst_i, .inc_i(1'b1), .inhibit_i(mcinh_q[0]),
      .we_lo_i(wr && addr_i == CSR_MCYCLE), .we_hi_i(wr && addr_i == CSR_MCYCLEH),
      .wdata_i(wval), .value_o(cy_val));
   csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_instret (
      .clk_i, .rst_i, .inc_i(instr_retired_i), .inhibit_i(mcinh_q[2]),
      .we_lo_i(wr && addr_i == CSR_MINSTRET), .we_hi_i(wr && addr_i == CSR_MINSTRETH),
      .wdata_i(wval), .value_o(ir_val));
   for (genvar g = 0; g < NUM_HPM; g++) begin : g_hpm
      csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hpm (
         .clk_i, .rst_i, .inc_i(hpm_event_i[g]), .inhibit_i(mcinh_q[3+g]),
         .we_lo_i(wr && addr_i == CSR_MHPMCOUNTER3 + 12'(g)), .we_hi_i(wr && addr_i == CSR_MHPMCOUNTER3H + 12'(g)),
         .wdata_i(wval), .value_o(hpm_val[g]));
   end
   if (NUM_HPM == 0) begin : g_nohpm
      assign hpm_val[0] = '0;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mtvec_q        <= MTVEC_RESET;
         mie_q          <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mtval_q        <= '0;
         mcinh_q        <= '0;
         irq_q          <= '0;
      end else begin
         irq_q <= {irq_ext_i, irq_timer_i, irq_soft_i};
         if (trap_i) begin
            mepc_q         <= trap_epc_i & ~32'h1;
            mcause_q       <= {trap_is_intr_i, 26'b0, trap_cause_i};
            mtval_q        <= trap_tval_i;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
         end else if (mret_i) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
         end else if (wr) begin
            case (addr_i)
               CSR_MSTATUS: begin
                  mstatus_mie_q  <= wval[MSTATUS_MIE];
                  mstatus_mpie_q <= wval[MSTATUS_MPIE];
               end
               CSR_MTVEC:         mtvec_q    <= wval;
               CSR_MIE:           mie_q      <= wval & MIE_MASK;
               CSR_MSCRATCH:      mscratch_q <= wval;
               CSR_MEPC:          mepc_q     <= wval & ~32'h1;
               CSR_MCAUSE:        mcause_q   <= wval;
               CSR_MTVAL:         mtval_q    <= wval;
               CSR_MCOUNTINHIBIT: mcinh_q    <= wval & MCI_MASK;
               default: ;
            endcase
         end
      end
   end
   assign pend           = mip & mie_q;
   assign intr_pending_o = mstatus_mie_q && |pend;
   assign intr_cause_o   = pend[11] ? IRQ_MEI : pend[3] ? IRQ_MSI : pend[7] ? IRQ_MTI : 5'd0;
   assign tbase          = {mtvec_q[31:2], 2'b00};
   assign trap_vec_o     = (mtvec_q[1:0] == 2'b01 && trap_is_intr_i) ? tbase + {25'b0, trap_cause_i, 2'b00} : tbase;
   assign mepc_o         = mepc_q;
endmodule

// File: tb/tb_csr_file_trap.sv
// tb_csr_file_trap: scoreboard-driven bench for the machine-mode CSR file
module tb_csr_file_trap;
   import csr_pkg::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic [11:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [1:0]  op = '0;
   logic        we = 1'b0, instr_ret = 1'b0;
   logic [3:0]  hpm_ev = '0;
   logic        irq_ext = 1'b0, irq_tim = 1'b0, irq_sw = 1'b0;
   logic        trap = 1'b0, tintr = 1'b0, mret = 1'b0;
   logic [4:0]  tcause = '0;
   logic [31:0] tepc = '0, ttval = '0;
   logic [31:0] data_o, tvec, mepc;
   logic        illegal, ipend;
   logic [4:0]  icause;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] e;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   csr_file_trap #(.VEND_ID(32'hABCD), .ARCH_ID(32'h2), .IMPL_ID(32'h3), .HART_ID(32'h5),
                   .NUM_HPM(4), .CNT_WIDTH(64), .MTVEC_RESET(32'h102)) dut (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata), .op_i(op), .we_i(we),
      .data_o(data_o), .illegal_o(illegal), .instr_retired_i(instr_ret), .hpm_event_i(hpm_ev),
      .irq_ext_i(irq_ext), .irq_timer_i(irq_tim), .irq_soft_i(irq_sw),
      .trap_i(trap), .trap_cause_i(tcause), .trap_is_intr_i(tintr), .trap_epc_i(tepc),
      .trap_tval_i(ttval), .mret_i(mret), .trap_vec_o(tvec), .mepc_o(mepc),
      .intr_pending_o(ipend), .intr_cause_o(icause));

   task automatic put(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d, input logic w);
      @(negedge clk);
      addr = a; op = o; wdata = d; we = w;
      #1;
   endtask

   task automatic drv(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d, input logic w, input logic [31:0] x);
      put(a, o, d, w);
      exp_q.push_back(x);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; addr = CSR_MCYCLE; op = OP_NONE; we = 1'b0; exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcycle_first: got %h exp %h", data_o, e); end
      drv(CSR_MCYCLE, OP_NONE, 0, 0, 32'h1);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcycle_second: got %h exp %h", data_o, e); end
      drv(CSR_MHARTID, OP_NONE, 0, 0, 32'h5);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mhartid: got %h exp %h", data_o, e); end
      drv(CSR_MISA, OP_NONE, 0, 0, 32'h4000_0100);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL misa: got %h exp %h", data_o, e); end
      drv(CSR_MVENDORID, OP_NONE, 0, 0, 32'hABCD);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mvendorid: got %h exp %h", data_o, e); end
      drv(CSR_MTVEC, OP_NONE, 0, 0, 32'h102);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mtvec_reset: got %h exp %h", data_o, e); end
      n_cmp++; if (tvec !== 32'h100) begin n_err++; $display("FAIL trap_vec_reset: got %h exp 00000100", tvec); end
      n_cmp++; if (ipend !== 1'b0) begin n_err++; $display("FAIL ipend_reset: got %b exp 0", ipend); end
      n_cmp++; if (mepc !== 32'h0) begin n_err++; $display("FAIL mepc_reset: got %h exp 0", mepc); end
      drv(CSR_MSTATUS, OP_NONE, 0, 0, 32'h1800);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mstatus_reset: got %h exp %h", data_o, e); end
      drv(CSR_MINSTRET, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL minstret_reset: got %h exp %h", data_o, e); end
   endtask

   task automatic test_rw_rs_rc;
      drv(CSR_MSCRATCH, OP_RW, 32'h0F, 1, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mscratch_rw: got %h exp %h", data_o, e); end
      drv(CSR_MSCRATCH, OP_RS, 32'hF0, 1, 32'h0F);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mscratch_rs: got %h exp %h", data_o, e); end
      drv(CSR_MSCRATCH, OP_RC, 32'h0F, 1, 32'hFF);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mscratch_rc: got %h exp %h", data_o, e); end
      drv(CSR_MSCRATCH, OP_NONE, 0, 1, 32'hF0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mscratch_final: got %h exp %h", data_o, e); end
   endtask

   task automatic test_counters;
      put(CSR_MCYCLE, OP_RW, 32'hFFFF_FFFF, 1);
      put(CSR_MCYCLEH, OP_RW, 32'hFFFF_FFFF, 1);
      drv(CSR_MCYCLEH, OP_NONE, 0, 0, 32'hFFFF_FFFF);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcycleh_max: got %h exp %h", data_o, e); end
      drv(CSR_MCYCLE, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcycle_wrap: got %h exp %h", data_o, e); end
      drv(CSR_MCYCLEH, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcycleh_wrap: got %h exp %h", data_o, e); end
      drv(CSR_MCOUNTINHIBIT, OP_RW, 32'hFFFF_FFFF, 1, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcinh_old: got %h exp %h", data_o, e); end
      drv(CSR_MCOUNTINHIBIT, OP_NONE, 0, 0, 32'h7D);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcinh_mask: got %h exp %h", data_o, e); end
      instr_ret = 1'b1;
      drv(CSR_MCYCLE, OP_NONE, 0, 0, 32'h3);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcycle_frozen1: got %h exp %h", data_o, e); end
      drv(CSR_INSTRET, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL instret_frozen: got %h exp %h", data_o, e); end
      instr_ret = 1'b0;
      drv(CSR_CYCLE, OP_NONE, 0, 0, 32'h3);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL cycle_frozen2: got %h exp %h", data_o, e); end
      put(CSR_MCOUNTINHIBIT, OP_RW, 32'h0, 1);
      drv(CSR_MHPMCOUNTER3 + 12'd1, OP_RW, 32'h10, 1, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hpm4_old: got %h exp %h", data_o, e); end
      drv(CSR_MHPMCOUNTER3 + 12'd1, OP_NONE, 0, 0, 32'h10);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hpm4_written: got %h exp %h", data_o, e); end
      hpm_ev = 4'b0010; instr_ret = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drv(CSR_MHPMEVENT3 + 12'd1, OP_NONE, 0, 0, 32'h0);
         e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mhpmevent4_read: got %h exp %h", data_o, e); end
      end
      hpm_ev = 4'b0000; instr_ret = 1'b0;
      drv(CSR_MHPMCOUNTER3 + 12'd1, OP_NONE, 0, 0, 32'h13);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hpm4_count: got %h exp %h", data_o, e); end
      drv(CSR_MHPMCOUNTER3, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hpm3_idle: got %h exp %h", data_o, e); end
      drv(CSR_MINSTRET, OP_NONE, 0, 0, 32'h3);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL minstret_count: got %h exp %h", data_o, e); end
   endtask

   task automatic test_interrupts;
      drv(CSR_MTVEC, OP_RW, 32'h1001, 1, 32'h102);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mtvec_old: got %h exp %h", data_o, e); end
      drv(CSR_MIE, OP_RW, 32'h800, 1, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mie_old: got %h exp %h", data_o, e); end
      drv(CSR_MSTATUS, OP_RS, 32'h8, 1, 32'h1800);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mstatus_pre_mie: got %h exp %h", data_o, e); end
      drv(CSR_MIP, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mip_idle: got %h exp %h", data_o, e); end
      irq_ext = 1'b1;
      #1;
      n_cmp++; if (ipend !== 1'b0) begin n_err++; $display("FAIL ipend_before_sync: got %b exp 0", ipend); end
      drv(CSR_MIP, OP_NONE, 0, 0, 32'h800);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mip_meip: got %h exp %h", data_o, e); end
      n_cmp++; if (ipend !== 1'b1) begin n_err++; $display("FAIL ipend_ext: got %b exp 1", ipend); end
      n_cmp++; if (icause !== 5'd11) begin n_err++; $display("FAIL icause_ext: got %0d exp 11", icause); end
      tintr = 1'b1; tcause = 5'd11;
      #1;
      n_cmp++; if (tvec !== 32'h102C) begin n_err++; $display("FAIL tvec_vectored: got %h exp 0000102c", tvec); end
      tintr = 1'b0;
      #1;
      n_cmp++; if (tvec !== 32'h1000) begin n_err++; $display("FAIL tvec_exception: got %h exp 00001000", tvec); end
      tintr = 1'b1; trap = 1'b1; tepc = 32'h3001; ttval = 32'h77;
      drv(CSR_MSTATUS, OP_NONE, 0, 0, 32'h1880);
      trap = 1'b0; tintr = 1'b0;
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mstatus_after_trap: got %h exp %h", data_o, e); end
      n_cmp++; if (ipend !== 1'b0) begin n_err++; $display("FAIL ipend_masked: got %b exp 0", ipend); end
      n_cmp++; if (mepc !== 32'h3000) begin n_err++; $display("FAIL mepc_trap: got %h exp 00003000", mepc); end
      drv(CSR_MCAUSE, OP_NONE, 0, 0, 32'h8000_000B);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mcause_trap: got %h exp %h", data_o, e); end
      drv(CSR_MTVAL, OP_NONE, 0, 0, 32'h77);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mtval_trap: got %h exp %h", data_o, e); end
      put(CSR_MIE, OP_RW, 32'hFFFF_FFFF, 1);
      irq_sw = 1'b1; irq_tim = 1'b1;
      put(CSR_MSTATUS, OP_RS, 32'h8, 1);
      drv(CSR_MIP, OP_NONE, 0, 0, 32'h888);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mip_all: got %h exp %h", data_o, e); end
      n_cmp++; if (icause !== 5'd11) begin n_err++; $display("FAIL prio_mei: got %0d exp 11", icause); end
      irq_ext = 1'b0;
      drv(CSR_MIE, OP_NONE, 0, 0, 32'h888);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mie_mask: got %h exp %h", data_o, e); end
      n_cmp++; if (icause !== 5'd3) begin n_err++; $display("FAIL prio_msi: got %0d exp 3", icause); end
      irq_sw = 1'b0;
      drv(CSR_MIP, OP_RW, 32'hFFFF_FFFF, 1, 32'h80);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mip_mti: got %h exp %h", data_o, e); end
      n_cmp++; if (icause !== 5'd7) begin n_err++; $display("FAIL prio_mti: got %0d exp 7", icause); end
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL mip_write_legal: got %b exp 0", illegal); end
      irq_tim = 1'b0;
      drv(CSR_MIP, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mip_clear: got %h exp %h", data_o, e); end
      n_cmp++; if (ipend !== 1'b0) begin n_err++; $display("FAIL ipend_clear: got %b exp 0", ipend); end
   endtask

   task automatic test_back_to_back;
      drv(CSR_MEPC, OP_RW, 32'h5555, 1, 32'h3000);
      trap = 1'b1; tepc = 32'h2000; tcause = 5'd2; tintr = 1'b0; ttval = 32'h0;
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mepc_pre: got %h exp %h", data_o, e); end
      drv(CSR_MEPC, OP_NONE, 0, 0, 32'h2000);
      trap = 1'b0;
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mepc_trap_wins: got %h exp %h", data_o, e); end
      drv(CSR_MSCRATCH, OP_RW, 32'hDEAD, 1, 32'hF0);
      mret = 1'b1;
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mstatus_pre_mret_read: got %h exp %h", data_o, e); end
      drv(CSR_MSCRATCH, OP_NONE, 0, 0, 32'hF0);
      mret = 1'b0;
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mscratch_mret_wins: got %h exp %h", data_o, e); end
      n_cmp++; if (mepc !== 32'h2000) begin n_err++; $display("FAIL mepc_o_mret: got %h exp 00002000", mepc); end
      drv(CSR_MSTATUS, OP_NONE, 0, 0, 32'h1888);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mstatus_after_mret: got %h exp %h", data_o, e); end
      put(CSR_MEPC, OP_RW, 32'h1235, 1);
      drv(CSR_MEPC, OP_NONE, 0, 0, 32'h1234);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mepc_bit0: got %h exp %h", data_o, e); end
   endtask

   task automatic test_illegal;
      drv(CSR_MHARTID, OP_RW, 32'h99, 1, 32'h5);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hartid_wr_read: got %h exp %h", data_o, e); end
      n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL hartid_wr_illegal: got %b exp 1", illegal); end
      drv(CSR_MHARTID, OP_NONE, 0, 0, 32'h5);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hartid_unchanged: got %h exp %h", data_o, e); end
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL hartid_rd_legal: got %b exp 0", illegal); end
      drv(12'h7FF, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL unimpl_data: got %h exp %h", data_o, e); end
      n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL unimpl_illegal: got %b exp 1", illegal); end
      drv(CSR_MHPMCOUNTER3 + 12'd4, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL hpm7_data: got %h exp %h", data_o, e); end
      n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL hpm7_illegal: got %b exp 1", illegal); end
      put(CSR_CYCLE, OP_RS, 32'h0, 1);
      n_cmp++; if (illegal !== 1'b1) begin n_err++; $display("FAIL cycle_wr_illegal: got %b exp 1", illegal); end
      put(CSR_CYCLE, OP_RS, 32'h0, 0);
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL cycle_rd_legal: got %b exp 0", illegal); end
      drv(CSR_MHPMEVENT3, OP_RW, 32'h5, 1, 32'h0);
      n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL mhpmevent_wr_legal: got %b exp 0", illegal); end
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mhpmevent_pre: got %h exp %h", data_o, e); end
      drv(CSR_MHPMEVENT3, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mhpmevent_ignored: got %h exp %h", data_o, e); end
      drv(CSR_MSTATUSH, OP_NONE, 0, 0, 32'h0);
      e = exp_q.pop_front(); n_cmp++; if (data_o !== e) begin n_err++; $display("FAIL mstatush: got %h exp %h", data_o, e); end
   endtask

   initial begin
      test_reset;
      test_rw_rs_rc;
      test_counters;
      test_interrupts;
      test_back_to_back;
      test_illegal;
      put(12'h000, OP_NONE, 0, 0);
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/csr_file_trap.md
Name: csr_file_trap

Overview:
Parametrised machine-mode CSR file for the Atom core. It adds the following to the existing counter/ID CSR set:
- configurable hardware performance counters, with event inputs and `mcountinhibit`;
- trap entry and `mret` sequencing;
- interrupt pending/enable/priority logic;
- illegal-access detection.

It sits beside the execute stage: single-cycle combinational read, registered write, trap/return updates on the clock edge.

Parameters:
VEND_ID, 32'h0, value returned by `mvendorid`
ARCH_ID, 32'h0, value returned by `marchid`
IMPL_ID, 32'h0, value returned by `mimpid`
HART_ID, 32'h0, value returned by `mhartid`
NUM_HPM, 4, number of `mhpmcounter3..(3+NUM_HPM-1)` implemented; range 0..29
CNT_WIDTH, 64, width of `mcycle`/`minstret`/hpm counters; range 33..64, upper bits read as 0
MTVEC_RESET, 32'h0, reset value of `mtvec`

Ports:
clk_i  in  1  clock
rst_i  in  1  reset
addr_i  in  12  CSR address
data_i  in  32  write operand (rs1 or zimm)
op_i  in  2  01 = RW, 10 = RS, 11 = RC, 00 = no write
we_i  in  1  CSR instruction commits this cycle
data_o  out  32  current (pre-write) value of the addressed CSR
illegal_o  out  1  access is illegal (combinational)
instr_retired_i  in  1  `minstret` increment
hpm_event_i  in  NUM_HPM  one increment strobe per hpm counter
irq_ext_i / irq_timer_i / irq_soft_i  in  1 each  level interrupt lines
trap_i  in  1  take trap this cycle
trap_cause_i  in  5  exception/interrupt code
trap_is_intr_i  in  1  sets `mcause[31]`
trap_epc_i  in  32  faulting/interrupted PC
trap_tval_i  in  32  `mtval` value
mret_i  in  1  execute `mret`
trap_vec_o  out  32  handler target
mepc_o  out  32  `mepc` for `mret`
intr_pending_o  out  1  enabled interrupt awaiting service
intr_cause_o  out  5  code of highest-priority pending interrupt

Behaviour:
- Clock/reset:
  - One clock `clk_i`.
  - `rst_i` is synchronous and active-high.
- Reset values:
  - All counters = 0.
  - `mstatus.MIE` = 0, `mstatus.MPIE` = 0.
  - `mie` = 0, `mcountinhibit` = 0, `mepc` = 0, `mcause` = 0, `mtval` = 0, `mscratch` = 0.
  - `mtvec` = MTVEC_RESET.
  - Outputs after reset: `intr_pending_o` = 0, `mepc_o` = 0, `trap_vec_o` = `MTVEC_RESET & ~3`.
- Read path:
  - `data_o` is combinational from `addr_i`, zero latency.
  - Unimplemented addresses return 0.
- Write value:
  - RW: `data_i`.
  - RS: `read | data_i`.
  - RC: `read & ~data_i`.
  - The write is applied at the next posedge when `we_i` is high and `op_i` != 0.
- `illegal_o` = 1 when either:
  - `addr_i` is unimplemented; or
  - `we_i` is high with a write op to a read-only address (`addr[11:10]==2'b11`).
- When `illegal_o` is high, no state changes.
- Implemented CSRs:
  - `cycle`/`h`, `instret`/`h`, `mcycle`/`h`, `minstret`/`h`.
  - `mhpmcounterN`/`h`, `mhpmeventN` (read 0, writes ignored).
  - `mvendorid`, `marchid`, `mimpid`, `mhartid`, `misa`.
  - `mstatus`: MIE bit 3, MPIE bit 7, MPP bits 12:11 fixed 2'b11.
  - `mstatush` (0), `mtvec`, `mie`, `mip`, `mscratch`, `mepc`, `mcause`, `mtval`, `mcountinhibit`.
- Counters:
  - `mcycle` increments every cycle unless inhibited.
  - `minstret` increments on `instr_retired_i`; hpm counter N increments on `hpm_event_i[N-3]`.
  - `mcountinhibit` bit 0 = CY, bit 2 = IR, bit 3+ = HPM; bit 1 is read-only 0.
  - Counters wrap to 0 at `2^CNT_WIDTH`.
  - A CSR write to a counter half replaces that half and suppresses the increment in that cycle.
- `mip`:
  - Read-only.
  - MEIP/MTIP/MSIP are the irq inputs registered once (1-cycle delay).
  - Writes are ignored and not illegal.
- Interrupts:
  - pend = `mip & mie`.
  - `intr_pending_o = mstatus.MIE & |pend`.
  - Priority MEI(11) > MSI(3) > MTI(7); `intr_cause_o` = the winning code.
- Trap entry (`trap_i`):
  - `mepc <= trap_epc_i & ~1`.
  - `mcause <= {trap_is_intr_i, 26'b0, trap_cause_i}`.
  - `mtval <= trap_tval_i`.
  - `MPIE <= MIE`, `MIE <= 0`.
- `trap_vec_o`:
  - Direct (mode 0) or mode >= 2: `base`.
  - Vectored (mode 1) with `trap_is_intr_i`: `base + 4*trap_cause_i`.
- `mret_i`: `MIE <= MPIE`, `MPIE <= 1`.
- Simultaneous events, priority trap > mret > CSR write:
  - The losing write is dropped.
  - Counter increments still occur.
- `mepc` bit 0 always reads 0.
- `mtvec` mode bits 1 are writable; mode 2/3 behave as direct.

Decomposition:
- Package `csr_pkg`: CSR address constants (extend `CSR_defs`), op encodings, `mcause` codes, `mstatus` bit positions.
- Sub-module `csr_counter`:
  - Parameter CNT_WIDTH.
  - Ports: inc, inhibit, lo/hi write enables, write data, value.
  - Instantiated for `mcycle`, `minstret`, and NUM_HPM times via generate.

Test Plan:
- Reset then read `misa`/`mhartid`/`mtvec` → `mhartid` = HART_ID; `mtvec` = MTVEC_RESET; `mcycle` reads 0 on the first cycle after reset and 1 on the next.
- CSRRS on `mscratch` with 0xF0 after RW of 0x0F → `data_o` 0x0F, then 0xFF; CSRRC 0x0F → 0xF0.
- Write `mcycle` = 0xFFFFFFFF and `mcycleh` = 0xFFFFFFFF → the next cycle reads `mcycle` = 0 and `mcycleh` = 0 (wrap); with `mcountinhibit.CY` = 1 the value is frozen.
- `mtvec` = 0x1001, `mie.MEIE` = 1, `MIE` = 1, `irq_ext_i` = 1 → `intr_pending_o` = 1 after 1 cycle, `intr_cause_o` = 11; with `trap_is_intr_i` = 1 and cause 11, `trap_vec_o` = 0x102C; after `trap_i`, `mstatus` reads 0x1880.
- Same-cycle `trap_i` and CSRRW to `mepc` (0x5555) with `trap_epc_i` 0x2000 → `mepc` = 0x2000; a following `mret_i` gives `mepc_o` 0x2000 and `mstatus.MIE` = 1.
- CSRRW to `mhartid` → `illegal_o` = 1, value unchanged; read of address 0x7FF → `illegal_o` = 1, `data_o` = 0.
